// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types for the serial-in/parallel-out controller.
// Holds the frame FSM state encoding used by sipo_ctrl.
package sipo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : sipo_pkg

// File: rtl/sipo_ce.sv
// sipo_ce: shift register with clock enable and synchronous clear.
// Ports: clk_i, rst_ni (async low), clr_i, en_i, bit_i; q_o current, d_o shifted.
module sipo_ce #(
  parameter int BITS        = 8,
  parameter int SHIFT_RIGHT = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            bit_i,
  output logic [BITS-1:0] q_o,
  output logic [BITS-1:0] d_o
);

  logic [BITS-1:0] sr_q;

  // d_o is the value after shifting bit_i in, so the caller can
  // capture a completed word on the same edge that shifts it.
  always_comb begin
    if (SHIFT_RIGHT != 0) begin
      d_o = {bit_i, sr_q[BITS-1:1]};
    end else begin
      d_o = {sr_q[BITS-2:0], bit_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else if (clr_i) begin
      sr_q <= '0;
    end else if (en_i) begin
      sr_q <= d_o;
    end
  end

  assign q_o = sr_q;

endmodule : sipo_ce

// File: rtl/sipo_ctrl.sv
// sipo_ctrl: framed serial-to-parallel converter with a one-word
// valid/ready output buffer and a sticky overrun flag.
module sipo_ctrl
  import sipo_pkg::*;
#(
  parameter int BITS        = 8,
  parameter int SHIFT_RIGHT = 1
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_start,
  input  logic            in_abort,
  input  logic            in_serial,
  input  logic            in_serial_valid,
  input  logic            in_word_ready,
  input  logic            in_ovr_clr,
  output logic            out_busy,
  output logic [BITS-1:0] out_word,
  output logic            out_word_valid,
  output logic            out_overrun
);

  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [BITS-1:0] word_q, word_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;

  logic            in_shift;
  logic            go;
  logic            kill;
  logic            strobe;
  logic            done;
  logic            consume;
  logic            sr_clr;
  logic [BITS-1:0] sr_cur;
  logic [BITS-1:0] sr_nxt;

  assign in_shift = (state_q == ST_SHIFT);
  assign go       = !in_shift && in_start;
  assign kill     = in_shift && in_abort;
  // Abort wins over a strobe in the same cycle.
  assign strobe   = in_shift && !in_abort
                 && in_serial_valid;
  assign done     = strobe && (cnt_q == LAST);
  assign consume  = valid_q && in_word_ready;
  assign sr_clr   = go || kill;

  sipo_ce #(
    .BITS        (BITS),
    .SHIFT_RIGHT (SHIFT_RIGHT)
  ) u_sr (
    .clk_i  (in_clk),
    .rst_ni (in_rst),
    .clr_i  (sr_clr),
    .en_i   (strobe),
    .bit_i  (in_serial),
    .q_o    (sr_cur),
    .d_o    (sr_nxt)
  );

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_start) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end
        end
        ST_SHIFT: begin
          if (in_abort) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (in_serial_valid) begin
            if (cnt_q == LAST) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // A completing word takes the buffer only if it is empty or being
  // drained this edge; otherwise the new word is dropped.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (in_ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (done) begin
      if (!valid_q || consume) begin
        word_d  = sr_nxt;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  logic unused_sr;
  assign unused_sr = ^sr_cur;

  assign out_busy       = in_shift;
  assign out_word       = word_q;
  assign out_word_valid = valid_q;
  assign out_overrun    = ovr_q;

endmodule : sipo_ctrl

// File: tb/tb_sipo_ctrl.sv
// tb_sipo_ctrl: randomized and directed checks of sipo_ctrl against
// a bit-queue reference model, both shift directions side by side.
module tb_sipo_ctrl;

  localparam int BITS = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ser = 1'b0;
  logic sv = 1'b0;
  logic rdy = 1'b0;
  logic oclr = 1'b0;

  logic            busy1, wv1, ovr1;
  logic [BITS-1:0] word1;
  logic            busy0, wv0, ovr0;
  logic [BITS-1:0] word0;

  int nchk = 0;
  int nbad = 0;

  // model state
  bit              m_busy;
  bit              bq[$];
  logic [BITS-1:0] m_w1, m_w0;
  bit              m_v, m_o;

  always #5 clk = ~clk;

  sipo_ctrl #(.BITS(BITS), .SHIFT_RIGHT(1)) dut (
    .in_clk          (clk),
    .in_rst          (rst),
    .in_start        (start),
    .in_abort        (abort),
    .in_serial       (ser),
    .in_serial_valid (sv),
    .in_word_ready   (rdy),
    .in_ovr_clr      (oclr),
    .out_busy        (busy1),
    .out_word        (word1),
    .out_word_valid  (wv1),
    .out_overrun     (ovr1)
  );

  sipo_ctrl #(.BITS(BITS), .SHIFT_RIGHT(0)) dut0 (
    .in_clk          (clk),
    .in_rst          (rst),
    .in_start        (start),
    .in_abort        (abort),
    .in_serial       (ser),
    .in_serial_valid (sv),
    .in_word_ready   (rdy),
    .in_ovr_clr      (oclr),
    .out_busy        (busy0),
    .out_word        (word0),
    .out_word_valid  (wv0),
    .out_overrun     (ovr0)
  );

  task automatic model_reset();
    m_busy = 0;
    bq.delete();
    m_w1 = '0;
    m_w0 = '0;
    m_v = 0;
    m_o = 0;
  endtask

  // First received bit lands in the LSB when shifting right,
  // in the MSB when shifting left.
  task automatic model_edge();
    bit done;
    bit cons;
    logic [BITS-1:0] a, b;
    done = 0;
    cons = m_v && rdy;
    if (m_busy) begin
      if (abort) begin
        m_busy = 0;
        bq.delete();
      end else if (sv) begin
        bq.push_back(ser);
        if (bq.size() == BITS) begin
          done = 1;
          m_busy = 0;
        end
      end
    end else if (start) begin
      m_busy = 1;
      bq.delete();
    end
    if (oclr) m_o = 0;
    if (done) begin
      a = '0;
      b = '0;
      for (int i = 0; i < BITS; i++) begin
        a[i] = bq[i];
        b[BITS-1-i] = bq[i];
      end
      bq.delete();
      if (!m_v || cons) begin
        m_w1 = a;
        m_w0 = b;
        m_v = 1;
      end else begin
        m_o = 1;
      end
    end else if (cons) begin
      m_v = 0;
    end
  endtask

  task automatic drive(input logic st, input logic ab,
                       input logic sr, input logic s,
                       input logic rd, input logic oc);
    @(negedge clk);
    start = st;
    abort = ab;
    ser = sr;
    sv = s;
    rdy = rd;
    oclr = oc;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic frame(input logic [BITS-1:0] w,
                       input logic lrdy, input logic loc);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < BITS; i++) begin
      if (i == BITS - 1) drive(0, 0, w[i], 1, lrdy, loc);
      else drive(0, 0, w[i], 1, 0, 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #2;
    nchk++;
    if (busy1 !== 1'b0 || busy0 !== 1'b0) begin
      nbad++;
      $display("FAIL reset_busy got=%b/%b want=0", busy1, busy0);
    end
    nchk++;
    if (word1 !== '0 || word0 !== '0) begin
      nbad++;
      $display("FAIL reset_word got=%h/%h want=00", word1, word0);
    end
    nchk++;
    if (wv1 !== 1'b0 || ovr1 !== 1'b0) begin
      nbad++;
      $display("FAIL reset_flags got=%b%b want=00", wv1, ovr1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [BITS-1:0] seq;
    seq = 8'h4D;
    drive(1, 0, 1, 1, 0, 0);
    nchk++;
    if (busy1 !== 1'b1) begin
      nbad++;
      $display("FAIL start_busy got=%b want=1", busy1);
    end
    for (int i = 0; i < BITS; i++) begin
      drive(i == 3, 0, seq[i], 1, 0, 0);
      if (i == BITS - 2) begin
        nchk++;
        if (wv1 !== 1'b0 || busy1 !== 1'b1) begin
          nbad++;
          $display("FAIL bit7_state got=v%b b%b want=v0 b1", wv1, busy1);
        end
      end
    end
    nchk++;
    if (word1 !== 8'h4D) begin
      nbad++;
      $display("FAIL right_word got=%h want=4d", word1);
    end
    nchk++;
    if (word0 !== 8'hB2) begin
      nbad++;
      $display("FAIL left_word got=%h want=b2", word0);
    end
    nchk++;
    if (wv1 !== 1'b1 || busy1 !== 1'b0) begin
      nbad++;
      $display("FAIL done_flags got=v%b b%b want=v1 b0", wv1, busy1);
    end
    drive(0, 1, 0, 0, 0, 0);
    nchk++;
    if (busy1 !== 1'b0 || word1 !== 8'h4D || wv1 !== 1'b1) begin
      nbad++;
      $display("FAIL idle_abort got=b%b %h v%b want=b0 4d v1", busy1, word1, wv1);
    end
    drive(0, 0, 0, 0, 1, 0);
    nchk++;
    if (wv1 !== 1'b0 || wv0 !== 1'b0) begin
      nbad++;
      $display("FAIL consume got=%b/%b want=0", wv1, wv0);
    end
  endtask

  task automatic test_overrun();
    frame(8'h4D, 0, 0);
    frame(8'hFF, 0, 0);
    nchk++;
    if (word1 !== 8'h4D || wv1 !== 1'b1) begin
      nbad++;
      $display("FAIL ovr_hold got=%h v%b want=4d v1", word1, wv1);
    end
    nchk++;
    if (ovr1 !== 1'b1 || ovr0 !== 1'b1) begin
      nbad++;
      $display("FAIL ovr_set got=%b/%b want=1", ovr1, ovr0);
    end
    drive(0, 0, 0, 0, 0, 1);
    nchk++;
    if (ovr1 !== 1'b0) begin
      nbad++;
      $display("FAIL ovr_clr got=%b want=0", ovr1);
    end
    frame(8'h12, 0, 1);
    nchk++;
    if (ovr1 !== 1'b1 || word1 !== 8'h4D) begin
      nbad++;
      $display("FAIL ovr_set_wins got=%b %h want=1 4d", ovr1, word1);
    end
    drive(0, 0, 0, 0, 1, 1);
    nchk++;
    if (ovr1 !== 1'b0 || wv1 !== 1'b0) begin
      nbad++;
      $display("FAIL ovr_drain got=o%b v%b want=o0 v0", ovr1, wv1);
    end
  endtask

  task automatic test_back_to_back();
    frame(8'h4D, 0, 0);
    frame(8'hFF, 1, 0);
    nchk++;
    if (word1 !== 8'hFF || wv1 !== 1'b1 || ovr1 !== 1'b0) begin
      nbad++;
      $display("FAIL b2b got=%h v%b o%b want=ff v1 o0", word1, wv1, ovr1);
    end
    drive(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_abort();
    frame(8'h3C, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1'($urandom), 1, 0, 0);
    drive(0, 1, 1, 1, 0, 0);
    nchk++;
    if (busy1 !== 1'b0 || word1 !== 8'h3C || wv1 !== 1'b1) begin
      nbad++;
      $display("FAIL abort got=b%b %h v%b want=b0 3c v1", busy1, word1, wv1);
    end
    drive(0, 0, 0, 0, 1, 0);
    frame(8'hA5, 0, 0);
    nchk++;
    if (word1 !== 8'hA5 || word0 !== 8'hA5 || wv1 !== 1'b1) begin
      nbad++;
      $display("FAIL after_abort got=%h/%h v%b want=a5/a5 v1", word1, word0, wv1);
    end
    drive(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_async_reset();
    frame(8'h77, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    nchk++;
    if (busy1 !== 1'b0 || word1 !== '0 || wv1 !== 1'b0 || ovr1 !== 1'b0) begin
      nbad++;
      $display("FAIL async_rst got=b%b %h v%b o%b want=0", busy1, word1, wv1, ovr1);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1'($urandom), 1, 0, 0);
      nchk++;
      if (busy1 !== 1'b0 || wv1 !== 1'b0 || wv0 !== 1'b0) begin
        nbad++;
        $display("FAIL no_start got=b%b v%b/%b want=0", busy1, wv1, wv0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(5) == 0, $urandom_range(24) == 0,
            1'($urandom), $urandom_range(3) != 0,
            $urandom_range(3) == 0, $urandom_range(11) == 0);
      nchk++;
      if (busy1 !== m_busy || busy0 !== m_busy) begin
        nbad++;
        $display("FAIL rnd_busy c%0d got=%b/%b want=%b", i, busy1, busy0, m_busy);
      end
      nchk++;
      if (wv1 !== m_v || wv0 !== m_v) begin
        nbad++;
        $display("FAIL rnd_valid c%0d got=%b/%b want=%b", i, wv1, wv0, m_v);
      end
      nchk++;
      if (ovr1 !== m_o || ovr0 !== m_o) begin
        nbad++;
        $display("FAIL rnd_ovr c%0d got=%b/%b want=%b", i, ovr1, ovr0, m_o);
      end
      nchk++;
      if (word1 !== m_w1 || word0 !== m_w0) begin
        nbad++;
        $display("FAIL rnd_word c%0d got=%h/%h want=%h/%h", i, word1, word0, m_w1, m_w0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule : tb_sipo_ctrl

// File: doc/sipo_ctrl.md
SIPO_CTRL -- requirements
Module: sipo_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 8, giving the word width in bits (>= 2).
REQ-002 SHALL have parameter SHIFT_RIGHT, default 1: 1 = new bit enters the MSB and moves toward the LSB; 0 = new bit enters the LSB and moves toward the MSB.
REQ-003 SHALL have port in_clk, input, 1 bit: the single clock; all flops update on its rising edge.
REQ-004 SHALL have port in_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_start, input, 1 bit: frame start request.
REQ-006 SHALL have port in_abort, input, 1 bit: cancels the frame in progress.
REQ-007 SHALL have port in_serial, input, 1 bit: serial data.
REQ-008 SHALL have port in_serial_valid, input, 1 bit: bit strobe; in_serial is sampled only when this is high.
REQ-009 SHALL have port in_word_ready, input, 1 bit: the consumer accepts out_word.
REQ-010 SHALL have port in_ovr_clr, input, 1 bit: clears out_overrun.
REQ-011 SHALL have port out_busy, output, 1 bit: high while a frame is in progress.
REQ-012 SHALL have port out_word, output, BITS bits: the assembled word.
REQ-013 SHALL have port out_word_valid, output, 1 bit: out_word holds an unconsumed word.
REQ-014 SHALL have port out_overrun, output, 1 bit: sticky flag, a completed word was dropped.

Function
REQ-015 SHALL implement an FSM with states IDLE and SHIFT; out_busy = (state == SHIFT).
REQ-016 IDLE: when in_start = 1, SHALL go to SHIFT and clear the bit counter; in_serial_valid in that same cycle SHALL be ignored.
REQ-017 SHIFT: on each cycle with in_serial_valid = 1, SHALL shift in_serial into the shift register per SHIFT_RIGHT and increment the bit counter (width clog2(BITS+1)).
REQ-018 SHIFT: in_start SHALL be ignored.
REQ-019 On the edge that samples the BITS-th bit, SHALL load the fully shifted value into the output register, return to IDLE and clear the counter; the new word SHALL be visible on out_word directly after that edge (zero extra latency).
REQ-020 Handshake: a word SHALL be consumed on any edge where out_word_valid = 1 and in_word_ready = 1.
REQ-021 Handshake: out_word SHALL stay stable while out_word_valid = 1 and the word has not been consumed.
REQ-022 Completion with the output buffer empty or consumed in the same cycle: SHALL load the new word and set out_word_valid = 1.
REQ-023 Completion with the output buffer full and not consumed: SHALL keep the old word, drop the new one and set out_overrun = 1.
REQ-024 A consumption without a simultaneous completion SHALL clear out_word_valid.
REQ-025 in_abort = 1 in SHIFT SHALL return to IDLE, clear the counter and discard the partial word; the output buffer and out_overrun SHALL be unaffected.
REQ-026 in_abort SHALL take priority over a bit strobe in the same cycle.
REQ-027 in_ovr_clr SHALL clear out_overrun; if an overrun occurs in the same cycle, the set SHALL win.
REQ-028 in_abort in IDLE SHALL have no effect.

Reset
REQ-029 in_rst = 0 SHALL asynchronously force: state IDLE, counter 0, shift register 0, out_word 0, out_word_valid 0, out_overrun 0, out_busy 0.
REQ-030 Reset in the middle of a frame SHALL discard the partial word; the first frame after reset release SHALL need a fresh in_start.

Structure
REQ-031 The FSM state enum SHALL live in shared package sipo_pkg.
REQ-032 The shift register SHALL be a sub-module sipo_ce (shift register with clock enable), parameterised by BITS and SHIFT_RIGHT, exposing both its current and its next value.
REQ-033 The counter, FSM, output buffer and overrun logic SHALL stay in sipo_ctrl.

Verification (BITS=8)
REQ-034 SHIFT_RIGHT=1: start, then bits 1,0,1,1,0,0,1,0 on consecutive strobes -> out_word = 0x4D, out_word_valid = 1 right after the 8th-bit edge, out_busy = 0.
REQ-035 SHIFT_RIGHT=0: same bit sequence -> out_word = 0xB2.
REQ-036 Word 0x4D held (in_word_ready = 0), second frame 0xFF completes -> out_word stays 0x4D, out_overrun = 1; then in_ovr_clr pulse -> out_overrun = 0.
REQ-037 in_word_ready = 1 on the same edge the second frame 0xFF completes -> out_word = 0xFF, out_word_valid stays 1, out_overrun = 0.
REQ-038 in_abort after 5 bits, then a new start and 8 bits 0xA5 -> out_word = 0xA5 with no residue from the aborted bits.
REQ-039 in_rst low after 3 bits -> all outputs 0 immediately (asynchronous); after release, in_serial_valid without in_start -> out_busy stays 0 and no word is produced.
